mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- MEM-stage controller between the EX/MEM pipeline register and the data-memory bus. Sits directly downstream of the execute stage; its registered outputs feed the MEM/WB register and the write-back mux.
- Converts a load/store request (ALU result as address, rs2 as store data, funct3 as size) into a multi-cycle req/ack bus transaction with byte strobes.
- Aligns and sign-extends load data, detects misaligned and illegal accesses, and times out stuck transactions. Stalls the upstream pipeline while a transaction is outstanding.

Parameters:
XLEN, 64, datapath and address width
TIMEOUT_CYCLES, 16, max cycles dmem_req may wait for dmem_ack before aborting
TO_W, 5, timeout counter width (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  EX/MEM slot holds a valid instruction
in_mem_read  in  1  load
in_mem_write  in  1  store (in_mem_read and in_mem_write never both high)
in_funct3  in  3  access size/sign
in_addr  in  XLEN  ALU result; address for memory ops, result for others
in_wdata  in  XLEN  store data (rs2)
in_rd  in  5  destination register
in_reg_write  in  1  write-back enable
stall  out  1  hold EX/MEM and all earlier stages
dmem_req  out  1  bus request, held until ack
dmem_we  out  1  1 = write
dmem_addr  out  XLEN  doubleword-aligned address (addr[2:0]=0)
dmem_wdata  out  XLEN  lane-shifted store data
dmem_wstrb  out  8  byte strobes
dmem_ack  in  1  one-cycle completion; rdata valid same cycle
dmem_rdata  in  XLEN  read doubleword
wb_valid  out  1  MEM/WB slot valid
wb_rd  out  5  destination register
wb_reg_write  out  1  write-back enable (forced 0 on exception)
wb_data  out  XLEN  aligned load data or passthrough ALU result
wb_exc  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3

Behaviour:
- Reset: state IDLE; all outputs 0, including dmem_* and wb_*; timeout counter 0. Asserting rst mid-transaction drops dmem_req immediately; the in-flight access is lost.
- Non-memory op, or in_valid=0: stall=0; on the next edge the wb_* registers capture inputs (wb_data=in_addr). Latency 1.
- Access check, combinational:
  - Loads: funct3 0/4 any alignment; 1/5 need addr[0]=0; 2/6 need addr[1:0]=0; 3 needs addr[2:0]=0; funct3 7 is illegal.
  - Stores: funct3 0..3 with the same alignment rules; funct3 >=4 is illegal.
  - On a fault: no bus request, stall=0, next edge writes wb_valid=1, wb_exc=01 or 11, wb_reg_write=0, wb_data=in_addr.
- FSM IDLE -> BUSY -> IDLE:
  - IDLE with a legal mem op: stall=1. Next edge: latch dmem_addr, we, wdata, wstrb, byte offset, funct3, rd, reg_write. Set dmem_req=1, clear counter, go to BUSY. wb_valid=0 on that edge.
  - BUSY without ack: stall=1, dmem_req stays 1, bus fields stable, counter increments.
  - BUSY with ack: stall=0. Next edge: dmem_req=0, wb_valid=1, wb_exc=00, wb_data=aligned load data (stores: wb_data=0, wb_reg_write=0); return to IDLE.
  - Timeout (counter==TIMEOUT_CYCLES-1 without ack): stall=0. Next edge: dmem_req=0, wb_valid=1, wb_exc=10, wb_reg_write=0; return to IDLE. An ack in the same cycle as timeout wins as success.
  - Minimum memory-op latency with ack on the first req cycle: 2 cycles.
- Stall contract: upstream holds in_* stable while stall=1. In IDLE, inputs are captured once; no re-request occurs while BUSY.
- Store lanes:
  - SB: wstrb=1<<off, byte replicated ×8.
  - SH: wstrb=3<<off, half replicated ×4.
  - SW: wstrb=0x0F<<off, word ×2.
  - SD: wstrb=0xFF.
- Load extract: shift rdata right by off*8, take 8/16/32/64 bits, sign-extend for funct3 0..2 and zero-extend for 4..6.
- Back-to-back memory ops: the IDLE re-entry edge accepts the next op immediately, so the throughput bound is 2 cycles per access.

Decomposition:
- Package riscv_mem_pkg holds:
  - funct3 constants (F3_B/H/W/D/BU/HU/WU);
  - exception codes EXC_NONE/MISALIGN/TIMEOUT/ILLEGAL;
  - FSM state enum (IDLE, BUSY).
- Sub-module load_store_align (combinational): store lane shift plus strobes, load extract plus extension, and the alignment/legality check. Reused later by the fetch-side bus interface.

Test Plan:
- Non-mem passthrough: in_valid=1, mem_read=0, in_addr=0x2A, rd=5 -> stall=0; next cycle wb_valid=1, wb_rd=5, wb_data=0x2A, no dmem_req.
- SB store: addr=0x103, wdata=0xAB, funct3=0, ack after 3 cycles -> dmem_addr=0x100, wstrb=0x08, wdata=0xABAB…AB; stall high for 4 cycles; then wb_valid with wb_reg_write=0.
- LB sign-extend: addr=0x105, rdata=0x0000_8000_0000_0000, funct3=0, immediate ack -> wb_data=0xFFFF_FFFF_FFFF_FF80. LBU on the same data -> 0x80.
- Misaligned LW: addr=0x102, funct3=2 -> no dmem_req; next cycle wb_exc=01, wb_reg_write=0. Illegal load funct3=7 -> wb_exc=11.
- Timeout: ack never asserted -> dmem_req high exactly 16 cycles, then wb_exc=10, stall drops. Repeat with ack in the 16th cycle -> success.
- Reset mid-BUSY: rst pulse while dmem_req=1 -> dmem_req, stall, and wb_* 0 asynchronously; the next legal LD (addr=0x8) completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// riscv_mem_pkg: funct3, exception and FSM encodings shared by the MEM-stage bus logic.
package riscv_mem_pkg;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_D  = 3'd3;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_WU = 3'd6;
    typedef enum logic [1:0] {EXC_NONE, EXC_MISALIGN, EXC_TIMEOUT, EXC_ILLEGAL} exc_t;
    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: req/ack data-memory bus with byte strobes.
interface mem_access_ctrl_if #(
    parameter int XLEN = 64
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [7:0]      wstrb;
    logic            ack;
    logic [XLEN-1:0] rdata;
    modport master(output req, we, addr, wdata, wstrb, input ack, rdata);
    modport slave(input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/mem_access_ctrl_align.sv
// load_store_align: store lane placement, load extraction/extension and access legality check.
module load_store_align
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [2:0]      off,
    input  logic            is_store,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] lane_wdata,
    output logic [7:0]      wstrb,
    output logic [XLEN-1:0] load_data,
    output exc_t            exc
);
    logic [1:0]      sz;
    logic [XLEN-1:0] sh;
    logic            sx;
    logic            illegal;
    logic            misalign;
    always_comb begin
        sz = funct3[1:0];
        sh = rdata >> {off, 3'b000};
        sx = ~funct3[2];
        lane_wdata = sz == F3_B[1:0] ? {(XLEN/8){wdata[7:0]}} :
                     sz == F3_H[1:0] ? {(XLEN/16){wdata[15:0]}} :
                     sz == F3_W[1:0] ? {(XLEN/32){wdata[31:0]}} : wdata;
        wstrb = sz == F3_B[1:0] ? 8'h01 << off :
                sz == F3_H[1:0] ? 8'h03 << off :
                sz == F3_W[1:0] ? 8'h0F << off : 8'hFF;
        load_data = sz == F3_B[1:0] ? {{(XLEN-8){sx & sh[7]}}, sh[7:0]} :
                    sz == F3_H[1:0] ? {{(XLEN-16){sx & sh[15]}}, sh[15:0]} :
                    sz == F3_W[1:0] ? {{(XLEN-32){sx & sh[31]}}, sh[31:0]} : sh;
        // unsigned variants only exist for loads, and there is no 64-bit unsigned load
        illegal = is_store ? funct3 >= F3_BU : funct3 == 3'd7;
        misalign = sz == F3_H[1:0] ? off[0] :
                   sz == F3_W[1:0] ? |off[1:0] :
                   sz == F3_D[1:0] ? |off : 1'b0;
        exc = illegal ? EXC_ILLEGAL : misalign ? EXC_MISALIGN : EXC_NONE;
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage controller turning EX/MEM load/store slots into req/ack bus
// transactions, with alignment, exception reporting, bus timeout and upstream stall.
module mem_access_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [4:0]        in_rd,
    input  logic              in_reg_write,
    output logic              stall,
    mem_access_ctrl_if.master dmem,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic [XLEN-1:0]   wb_data,
    output logic [1:0]        wb_exc
);
    state_t          state;
    logic [TO_W-1:0] cnt;
    logic [2:0]      off_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic            rw_q;
    logic            busy;
    logic            mem_op;
    logic            start;
    logic            fault;
    logic            timeout;
    logic [XLEN-1:0] lane_wdata;
    logic [XLEN-1:0] load_data;
    logic [7:0]      wstrb;
    exc_t            chk;

    // while busy the aligner works on the latched access so the load is extracted correctly
    load_store_align #(.XLEN(XLEN)) u_align (
        .funct3    (busy ? f3_q : in_funct3),
        .off       (busy ? off_q : in_addr[2:0]),
        .is_store  (busy ? dmem.we : in_mem_write),
        .wdata     (in_wdata),
        .rdata     (dmem.rdata),
        .lane_wdata(lane_wdata),
        .wstrb     (wstrb),
        .load_data (load_data),
        .exc       (chk)
    );

    always_comb begin
        busy = state == BUSY;
        mem_op = in_valid & (in_mem_read | in_mem_write);
        start = ~busy & mem_op & (chk == EXC_NONE);
        fault = ~busy & mem_op & (chk != EXC_NONE);
        timeout = busy & ~dmem.ack & (cnt == TO_W'(TIMEOUT_CYCLES - 1));
        stall = ~rst & (start | (busy & ~dmem.ack & ~timeout));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            off_q <= '0;
            f3_q <= '0;
            rd_q <= '0;
            rw_q <= 1'b0;
            dmem.req <= 1'b0;
            dmem.we <= 1'b0;
            dmem.addr <= '0;
            dmem.wdata <= '0;
            dmem.wstrb <= '0;
            wb_valid <= 1'b0;
            wb_rd <= '0;
            wb_reg_write <= 1'b0;
            wb_data <= '0;
            wb_exc <= '0;
        end else if (busy) begin
            if (dmem.ack | timeout) begin
                state <= IDLE;
                dmem.req <= 1'b0;
                wb_valid <= 1'b1;
                wb_rd <= rd_q;
                wb_reg_write <= dmem.ack & rw_q;
                wb_data <= dmem.ack & ~dmem.we ? load_data : '0;
                wb_exc <= dmem.ack ? EXC_NONE : EXC_TIMEOUT;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (start) begin
            state <= BUSY;
            cnt <= '0;
            off_q <= in_addr[2:0];
            f3_q <= in_funct3;
            rd_q <= in_rd;
            rw_q <= in_reg_write & in_mem_read;
            dmem.req <= 1'b1;
            dmem.we <= in_mem_write;
            dmem.addr <= {in_addr[XLEN-1:3], 3'b000};
            dmem.wdata <= lane_wdata;
            dmem.wstrb <= in_mem_write ? wstrb : 8'h00;
            wb_valid <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_exc <= EXC_NONE;
        end else begin
            wb_valid <= in_valid;
            wb_rd <= in_rd;
            wb_reg_write <= in_reg_write & ~fault;
            wb_data <= in_addr;
            wb_exc <= fault ? chk : EXC_NONE;
        end
    end
endmodule
